// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - Arbitrates the core's single memory port between fetch and load/store
// Data wins contention; fetch is forced through after STARVE_LIMIT back-to-back data grants.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        fetchReq,
  input  logic [31:0] fetchAddr,
  output logic [31:0] fetchRData,
  output logic        fetchValid,
  output logic        fetchErr,
  input  logic        dataReq,
  input  logic        dataWr,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataWData,
  input  logic [3:0]  dataMask,
  output logic [31:0] dataRData,
  output logic        dataValid,
  output logic        dataErr,
  output logic        memReq,
  output logic        memWr,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memMask,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} state_t;

  localparam logic [3:0] LP_STARVE  = 4'(STARVE_LIMIT);
  localparam logic [7:0] LP_TO_LAST = 8'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
  localparam bit         LP_TO_EN   = (TIMEOUT != 0);

  state_t      r_state;
  logic [3:0]  r_streak;
  logic [7:0]  r_wait_cnt;
  logic        w_grant_fetch;
  logic        w_grant_data;
  logic        w_timeout;

  always_comb begin
    w_grant_fetch = fetchReq && (!dataReq || (r_streak == LP_STARVE));
    w_grant_data  = dataReq && !w_grant_fetch;
    // The counter holds completed no-ack WAIT cycles, so the last one ends at TIMEOUT-1.
    w_timeout     = LP_TO_EN && (r_wait_cnt == LP_TO_LAST);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_streak   <= '0;
      r_wait_cnt <= '0;
      fetchRData <= '0;
      fetchValid <= 1'b0;
      fetchErr   <= 1'b0;
      dataRData  <= '0;
      dataValid  <= 1'b0;
      dataErr    <= 1'b0;
      memReq     <= 1'b0;
      memWr      <= 1'b0;
      memAddr    <= '0;
      memWData   <= '0;
      memMask    <= '0;
      busy       <= 1'b0;
    end else begin
      fetchValid <= 1'b0;
      fetchErr   <= 1'b0;
      dataValid  <= 1'b0;
      dataErr    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_grant_fetch) begin
            r_state  <= FETCH_WAIT;
            r_streak <= '0;
            memReq   <= 1'b1;
            memWr    <= 1'b0;
            memAddr  <= fetchAddr;
            memWData <= '0;
            memMask  <= 4'b1111;
            busy     <= 1'b1;
          end else if (w_grant_data) begin
            r_state  <= DATA_WAIT;
            r_streak <= fetchReq ? (r_streak + 4'd1) : 4'd0;
            memReq   <= 1'b1;
            memWr    <= dataWr;
            memAddr  <= dataAddr;
            memWData <= dataWData;
            memMask  <= dataMask;
            busy     <= 1'b1;
          end
        end
        FETCH_WAIT, DATA_WAIT: begin
          // Ack is checked first so an ack on the timeout cycle still completes normally.
          if (memAck) begin
            r_state <= IDLE;
            memReq  <= 1'b0;
            memWr   <= 1'b0;
            busy    <= 1'b0;
            if (r_state == FETCH_WAIT) begin
              fetchValid <= 1'b1;
              fetchRData <= memRData;
            end else begin
              dataValid <= 1'b1;
              if (!memWr) dataRData <= memRData;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
            memReq  <= 1'b0;
            memWr   <= 1'b0;
            busy    <= 1'b0;
            if (r_state == FETCH_WAIT) fetchErr <= 1'b1;
            else                       dataErr  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - Directed self-checking bench for memory_arbiter
// Instance a uses TIMEOUT=8, instance b uses TIMEOUT=4; both share the same stimulus.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        fetchReq, dataReq, dataWr, memAck;
  logic [31:0] fetchAddr, dataAddr, dataWData, memRData;
  logic [3:0]  dataMask;

  logic [31:0] a_fetchRData, a_dataRData, a_memAddr, a_memWData;
  logic        a_fetchValid, a_fetchErr, a_dataValid, a_dataErr, a_memReq, a_memWr, a_busy;
  logic [3:0]  a_memMask;
  logic [31:0] b_fetchRData, b_dataRData, b_memAddr, b_memWData;
  logic        b_fetchValid, b_fetchErr, b_dataValid, b_dataErr, b_memReq, b_memWr, b_busy;
  logic [3:0]  b_memMask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) u_a (
    .clk(clk), .resetN(resetN),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchRData(a_fetchRData),
    .fetchValid(a_fetchValid), .fetchErr(a_fetchErr),
    .dataReq(dataReq), .dataWr(dataWr), .dataAddr(dataAddr), .dataWData(dataWData),
    .dataMask(dataMask), .dataRData(a_dataRData), .dataValid(a_dataValid), .dataErr(a_dataErr),
    .memReq(a_memReq), .memWr(a_memWr), .memAddr(a_memAddr), .memWData(a_memWData),
    .memMask(a_memMask), .memAck(memAck), .memRData(memRData), .busy(a_busy)
  );

  memory_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(4)) u_b (
    .clk(clk), .resetN(resetN),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchRData(b_fetchRData),
    .fetchValid(b_fetchValid), .fetchErr(b_fetchErr),
    .dataReq(dataReq), .dataWr(dataWr), .dataAddr(dataAddr), .dataWData(dataWData),
    .dataMask(dataMask), .dataRData(b_dataRData), .dataValid(b_dataValid), .dataErr(b_dataErr),
    .memReq(b_memReq), .memWr(b_memWr), .memAddr(b_memAddr), .memWData(b_memWData),
    .memMask(b_memMask), .memAck(memAck), .memRData(memRData), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_f;
    resetN = 1'b0; fetchReq = 1'b0; dataReq = 1'b0; dataWr = 1'b0; memAck = 1'b0;
    fetchAddr = '0; dataAddr = '0; dataWData = '0; memRData = '0; dataMask = '0;
    tick();
    chk("rst_memReq", 32'(a_memReq), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_memMask", 32'(a_memMask), 32'd0);
    chk("rst_fetchRData", a_fetchRData, 32'd0);
    resetN = 1'b1;
    tick();

    // Single fetch, zero-wait memory
    fetchReq = 1'b1; fetchAddr = 32'h100;
    tick();
    chk("f1_memReq", 32'(a_memReq), 32'd1);
    chk("f1_busy", 32'(a_busy), 32'd1);
    chk("f1_memAddr", a_memAddr, 32'h100);
    chk("f1_memWr", 32'(a_memWr), 32'd0);
    chk("f1_memMask", 32'(a_memMask), 32'hf);
    chk("f1_memWData", a_memWData, 32'd0);
    chk("f1_valid_early", 32'(a_fetchValid), 32'd0);
    memAck = 1'b1; memRData = 32'hDEADBEEF;
    tick();
    chk("f1_fetchValid", 32'(a_fetchValid), 32'd1);
    chk("f1_fetchRData", a_fetchRData, 32'hDEADBEEF);
    chk("f1_memReq_drop", 32'(a_memReq), 32'd0);
    chk("f1_busy_drop", 32'(a_busy), 32'd0);
    fetchReq = 1'b0; memAck = 1'b0;
    tick();
    chk("f1_valid_pulse", 32'(a_fetchValid), 32'd0);
    chk("f1_no_regrant", 32'(a_memReq), 32'd0);

    // Contention with zero-wait acks: expected grants D,D,D,D,F,D,D,D,D,F
    fetchReq = 1'b1; fetchAddr = 32'h400;
    dataReq = 1'b1; dataWr = 1'b0; dataAddr = 32'h800; dataWData = 32'h0; dataMask = 4'hf;
    memAck = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_f = (k == 4) || (k == 9);
      tick();
      chk($sformatf("c%0d_memReq", k), 32'(a_memReq), 32'd1);
      chk($sformatf("c%0d_memAddr", k), a_memAddr, exp_f ? 32'h400 : 32'h800);
      memRData = 32'h1000 + 32'(k);
      tick();
      chk($sformatf("c%0d_fetchValid", k), 32'(a_fetchValid), 32'(exp_f));
      chk($sformatf("c%0d_dataValid", k), 32'(a_dataValid), 32'(!exp_f));
    end
    chk("c_fetchRData", a_fetchRData, 32'h1009);
    chk("c_dataRData", a_dataRData, 32'h1008);
    fetchReq = 1'b0; dataReq = 1'b0; memAck = 1'b0;
    tick();

    // Store with ack in the third WAIT cycle
    dataReq = 1'b1; dataWr = 1'b1; dataAddr = 32'h2004; dataWData = 32'h12345678; dataMask = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s%0d_memReq", i), 32'(a_memReq), 32'd1);
      chk($sformatf("s%0d_memWr", i), 32'(a_memWr), 32'd1);
      chk($sformatf("s%0d_memAddr", i), a_memAddr, 32'h2004);
      chk($sformatf("s%0d_memWData", i), a_memWData, 32'h12345678);
      chk($sformatf("s%0d_memMask", i), 32'(a_memMask), 32'h3);
    end
    memAck = 1'b1; memRData = 32'hCAFEF00D;
    tick();
    chk("s_dataValid", 32'(a_dataValid), 32'd1);
    chk("s_dataRData_kept", a_dataRData, 32'h1008);
    chk("s_memReq_drop", 32'(a_memReq), 32'd0);
    chk("s_memWr_drop", 32'(a_memWr), 32'd0);
    dataReq = 1'b0; memAck = 1'b0; dataWr = 1'b0;
    tick();
    chk("s_valid_pulse", 32'(a_dataValid), 32'd0);

    // Load timeout on instance a (TIMEOUT=8)
    dataReq = 1'b1; dataAddr = 32'h3000;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t%0d_memReq", i), 32'(a_memReq), 32'd1);
      chk($sformatf("t%0d_dataErr", i), 32'(a_dataErr), 32'd0);
    end
    tick();
    chk("t_dataErr", 32'(a_dataErr), 32'd1);
    chk("t_dataValid", 32'(a_dataValid), 32'd0);
    chk("t_memReq", 32'(a_memReq), 32'd0);
    chk("t_busy", 32'(a_busy), 32'd0);
    chk("t_dataRData", a_dataRData, 32'h1008);
    dataReq = 1'b0; memAck = 1'b1; memRData = 32'h55555555;
    tick();
    chk("t_spur_valid", 32'(a_dataValid), 32'd0);
    chk("t_spur_err", 32'(a_dataErr), 32'd0);
    chk("t_spur_memReq", 32'(a_memReq), 32'd0);
    chk("t_spur_rdata", a_dataRData, 32'h1008);
    memAck = 1'b0;
    tick();

    // Reset in the middle of a store
    dataReq = 1'b1; dataWr = 1'b1; dataAddr = 32'h5000; dataWData = 32'hFFFF0000; dataMask = 4'hc;
    tick();
    tick();
    chk("r_memReq_pre", 32'(a_memReq), 32'd1);
    resetN = 1'b0;
    #1;
    chk("r_memReq", 32'(a_memReq), 32'd0);
    chk("r_memWr", 32'(a_memWr), 32'd0);
    chk("r_memAddr", a_memAddr, 32'd0);
    chk("r_memWData", a_memWData, 32'd0);
    chk("r_memMask", 32'(a_memMask), 32'd0);
    chk("r_busy", 32'(a_busy), 32'd0);
    chk("r_dataRData", a_dataRData, 32'd0);
    chk("r_fetchRData", a_fetchRData, 32'd0);
    dataReq = 1'b0; dataWr = 1'b0;
    tick();
    chk("r_no_valid", 32'(a_dataValid), 32'd0);
    resetN = 1'b1;
    fetchReq = 1'b1; fetchAddr = 32'h600;
    tick();
    chk("r_fetch_memReq", 32'(a_memReq), 32'd1);
    chk("r_fetch_memAddr", a_memAddr, 32'h600);
    memAck = 1'b1; memRData = 32'hA5A5A5A5;
    tick();
    chk("r_fetchValid", 32'(a_fetchValid), 32'd1);
    chk("r_fetchRData", a_fetchRData, 32'hA5A5A5A5);
    fetchReq = 1'b0; memAck = 1'b0;
    tick();

    // Ack/timeout race on instance b (TIMEOUT=4): ack in the 4th WAIT cycle
    dataReq = 1'b1; dataWr = 1'b0; dataAddr = 32'h7000;
    tick();
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("x%0d_memReq", i), 32'(b_memReq), 32'd1);
    end
    memAck = 1'b1; memRData = 32'h0BADF00D;
    tick();
    chk("x_dataValid", 32'(b_dataValid), 32'd1);
    chk("x_dataErr", 32'(b_dataErr), 32'd0);
    chk("x_dataRData", b_dataRData, 32'h0BADF00D);
    chk("x_memReq", 32'(b_memReq), 32'd0);
    dataReq = 1'b0; memAck = 1'b0;
    tick();
    chk("x_err_after", 32'(b_dataErr), 32'd0);
    chk("x_busy_after", 32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
